// File: rtl/acumulador_pkg.sv
// rtl/acumulador_pkg.sv - shared state encoding and mode constants for acumulador_param
package acumulador_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_sat.sv
// rtl/addsub_sat.sv - combinational unsigned WIDTH-bit adder/subtractor with optional clamp
module addsub_sat #(
  parameter int WIDTH    = 16,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH:0] w_raw;

  // The extra MSB is carry-out for add and borrow for sub.
  assign w_raw   = i_sub ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});
  assign o_carry = w_raw[WIDTH];

  if (SATURATE != 0) begin : g_sat
    assign o_result = o_carry ? (i_sub ? '0 : '1) : w_raw[WIDTH-1:0];
  end else begin : g_wrap
    assign o_result = w_raw[WIDTH-1:0];
  end

endmodule

// File: rtl/acumulador_param.sv
// rtl/acumulador_param.sv - N-operand add/sub accumulator with Ready/Load handshake and Done pulse
module acumulador_param #(
  parameter int WIDTH    = 16,
  parameter int CNT_W    = 8,
  parameter int SATURATE = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             Sub,
  input  logic             Load,
  input  logic [WIDTH-1:0] DataIN,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow,
  output logic [CNT_W-1:0] OpCount,
  output logic [WIDTH-1:0] DataOut
);

  import acumulador_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_opcount;
  logic             r_mode;
  logic             r_ovf;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [CNT_W-1:0] w_opcount_inc;

  assign w_opcount_inc = r_opcount + 1'b1;

  addsub_sat #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_addsub (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_sub    (r_mode == MODE_SUB),
    .o_result (w_sum),
    .o_carry  (w_carry)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (Clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (Start) w_next = (Count != '0) ? ST_FETCH : ST_DONE;
        ST_FETCH: if (Load) w_next = ST_ADD;
        ST_ADD:   w_next = (w_opcount_inc == r_n) ? ST_DONE : ST_FETCH;
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // A is deliberately kept across runs so successive runs chain; only Clear/Reset zero it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_n       <= '0;
      r_mode    <= MODE_ADD;
      r_opcount <= '0;
      r_ovf     <= 1'b0;
    end else if (Clear) begin
      r_a       <= '0;
      r_opcount <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start && (Count != '0)) begin
            r_n       <= Count;
            r_mode    <= Sub;
            r_opcount <= '0;
          end
        end
        ST_FETCH: begin
          if (Load) r_b <= DataIN;
        end
        ST_ADD: begin
          r_a       <= w_sum;
          r_opcount <= w_opcount_inc;
          if (w_carry) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Ready    = (r_state == ST_FETCH);
  assign Busy     = (r_state != ST_IDLE);
  assign Done     = (r_state == ST_DONE);
  assign Overflow = r_ovf;
  assign OpCount  = r_opcount;
  assign DataOut  = r_a;

endmodule

// File: tb/tb_acumulador_param.sv
// tb/tb_acumulador_param.sv - self-checking bench for acumulador_param, wrap and saturating builds
module tb_acumulador_param;

  localparam int     W    = 16;
  localparam int     CW   = 8;
  localparam longint MAXV = (64'd1 << W) - 1;

  logic          Clock  = 1'b0;
  logic          Reset  = 1'b1;
  logic          Clear  = 1'b0;
  logic          Start  = 1'b0;
  logic [CW-1:0] Count  = '0;
  logic          Sub    = 1'b0;
  logic          Load   = 1'b0;
  logic [W-1:0]  DataIN = '0;

  logic          ready [2];
  logic          busy  [2];
  logic          done  [2];
  logic          ovf   [2];
  logic [CW-1:0] opc   [2];
  logic [W-1:0]  dout  [2];

  int     total = 0;
  int     bad   = 0;
  longint m_a   [2];
  bit     m_ovf [2];
  int     ops   [$];

  always #5 Clock = ~Clock;

  acumulador_param #(.WIDTH(W), .CNT_W(CW), .SATURATE(0)) u_wrap (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Start(Start), .Count(Count),
    .Sub(Sub), .Load(Load), .DataIN(DataIN), .Ready(ready[0]), .Busy(busy[0]),
    .Done(done[0]), .Overflow(ovf[0]), .OpCount(opc[0]), .DataOut(dout[0])
  );

  acumulador_param #(.WIDTH(W), .CNT_W(CW), .SATURATE(1)) u_sat (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .Start(Start), .Count(Count),
    .Sub(Sub), .Load(Load), .DataIN(DataIN), .Ready(ready[1]), .Busy(busy[1]),
    .Done(done[1]), .Overflow(ovf[1]), .OpCount(opc[1]), .DataOut(dout[1])
  );

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic string nm(input string tag, input int i);
    return {tag, (i == 0) ? "/wrap" : "/sat"};
  endfunction

  task automatic chk_acc(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk(nm({tag, ".dout"}, i), 32'(dout[i]), 32'(m_a[i]));
      chk(nm({tag, ".ovf"}, i), 32'(ovf[i]), 32'(m_ovf[i]));
    end
  endtask

  task automatic chk_ctl(input string tag, input bit rdy, input bit bsy, input bit dn);
    for (int i = 0; i < 2; i++) begin
      chk(nm({tag, ".ready"}, i), 32'(ready[i]), 32'(rdy));
      chk(nm({tag, ".busy"}, i), 32'(busy[i]), 32'(bsy));
      chk(nm({tag, ".done"}, i), 32'(done[i]), 32'(dn));
    end
  endtask

  task automatic chk_opc(input string tag, input int n);
    for (int i = 0; i < 2; i++) chk(nm({tag, ".opcount"}, i), 32'(opc[i]), 32'(n));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_a[i]   = 0;
      m_ovf[i] = 1'b0;
    end
  endtask

  // Unsigned arithmetic on wide integers; out-of-range means carry/borrow.
  task automatic model_apply(input longint b, input bit sub);
    for (int i = 0; i < 2; i++) begin
      longint r;
      r = sub ? (m_a[i] - b) : (m_a[i] + b);
      if (r > MAXV || r < 0) begin
        m_ovf[i] = 1'b1;
        if (i == 1) r = sub ? 0 : MAXV;
        else        r = sub ? (r + MAXV + 1) : (r - (MAXV + 1));
      end
      m_a[i] = r;
    end
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    model_reset();
    chk_ctl("clear", 0, 0, 0);
    chk_opc("clear", 0);
    chk_acc("clear");
  endtask

  task automatic run(input int cnt, input bit sub, input bit hold, input bit start_busy);
    Count = CW'(cnt);
    Sub   = sub;
    Start = 1'b1;
    step();
    Start = 1'b0;
    if (cnt == 0) begin
      chk_ctl("zero_done", 0, 1, 1);
      chk_acc("zero_acc");
      step();
      chk_ctl("zero_idle", 0, 0, 0);
      chk_acc("zero_idle");
      return;
    end
    chk_ctl("run_fetch", 1, 1, 0);
    if (start_busy) begin
      Start = 1'b1;
      Count = CW'(cnt + 3);
      Sub   = ~sub;
    end
    for (int k = 0; k < cnt; k++) begin
      int w;
      w = 0;
      while (ready[0] !== 1'b1 && w < 20) begin
        step();
        w++;
      end
      chk("ready_wait", 32'(ready[0]), 32'd1);
      DataIN = W'(ops[k]);
      Load   = 1'b1;
      step();
      if (!hold) Load = 1'b0;
      else       DataIN = W'($urandom);
      chk_ctl("in_add", 0, 1, 0);
      step();
      Start = 1'b0;
      model_apply(longint'(ops[k]), sub);
      chk_acc("after_add");
      chk_opc("opcount", k + 1);
      if (k == cnt - 1) chk_ctl("done", 0, 1, 1);
      else              chk_ctl("back_fetch", 1, 1, 0);
    end
    step();
    Load = 1'b0;
    chk_ctl("end_idle", 0, 0, 0);
    chk_opc("end_idle", cnt);
    chk_acc("end_idle");
  endtask

  initial begin
    model_reset();
    step();
    step();
    #3 Reset = 1'b0;
    chk_ctl("reset", 0, 0, 0);
    chk_opc("reset", 0);
    chk_acc("reset");

    do_clear();
    ops = '{5, 7, 9};
    run(3, 1'b0, 1'b0, 1'b0);
    chk("tp_sum21", 32'(dout[0]), 32'd21);

    ops = '{1, 4};
    run(2, 1'b1, 1'b1, 1'b0);
    chk("tp_sub16", 32'(dout[0]), 32'd16);

    step();
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk_ctl("async_reset", 0, 0, 0);
    chk_opc("async_reset", 0);
    chk_acc("async_reset");
    #2 Reset = 1'b0;
    step();

    do_clear();
    ops = '{'hFFF0, 'h0020};
    run(2, 1'b0, 1'b0, 1'b0);
    chk("tp_wrap", 32'(dout[0]), 32'h0010);
    chk("tp_sat", 32'(dout[1]), 32'hFFFF);

    do_clear();
    ops = '{1};
    run(1, 1'b1, 1'b0, 1'b0);
    chk("tp_sat_sub", 32'(dout[1]), 32'h0000);
    chk("tp_wrap_sub", 32'(dout[0]), 32'hFFFF);

    do_clear();
    ops = '{100, 23};
    run(2, 1'b0, 1'b0, 1'b0);
    run(0, 1'b0, 1'b0, 1'b0);
    ops = '{10, 20};
    run(2, 1'b0, 1'b0, 1'b1);
    chk("tp_busy_start", 32'(dout[0]), 32'd153);

    DataIN = 16'hABCD;
    Load   = 1'b1;
    step();
    step();
    Load = 1'b0;
    chk_ctl("idle_load", 0, 0, 0);
    chk_opc("idle_load", 2);
    chk_acc("idle_load");

    Count = 8'd3;
    Sub   = 1'b0;
    Start = 1'b1;
    step();
    Start  = 1'b0;
    DataIN = 16'd77;
    Load   = 1'b1;
    step();
    Load = 1'b0;
    step();
    model_apply(77, 1'b0);
    chk_acc("mid_fetch");
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    model_reset();
    chk_ctl("mid_clear", 0, 0, 0);
    chk_opc("mid_clear", 0);
    chk_acc("mid_clear");
    step();
    chk_ctl("mid_clear_nodone", 0, 0, 0);

    Start = 1'b1;
    step();
    Start  = 1'b0;
    DataIN = 16'd55;
    Load   = 1'b1;
    step();
    Load = 1'b0;
    #2 Reset = 1'b1;
    #1;
    chk_ctl("add_reset", 0, 0, 0);
    chk_opc("add_reset", 0);
    chk_acc("add_reset");
    #2 Reset = 1'b0;
    step();
    step();
    chk_ctl("add_reset_nodone", 0, 0, 0);
    chk_acc("add_reset_after");

    for (int r = 0; r < 10; r++) begin
      int cnt;
      bit sub;
      if ($urandom_range(0, 3) == 0) do_clear();
      cnt = $urandom_range(1, 5);
      sub = 1'($urandom_range(0, 1));
      ops.delete();
      for (int k = 0; k < cnt; k++) ops.push_back(int'($urandom & 32'hFFFF));
      run(cnt, sub, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acumulador_param.md
Name: acumulador_param

Overview:
Parametrised, clocked successor of the 16-bit load/transfer accumulator. It accepts a programmed number N of operands through a Ready/Load handshake and adds or subtracts each operand into accumulator register A. It flags unsigned overflow/underflow, with optional saturation, and pulses Done when the N-th operand has been applied. It is the datapath accumulator used by the memory-fed arithmetic blocks; DataOut always reflects A.

Parameters:
WIDTH, 16, data width of DataIN, operand register B and accumulator A
CNT_W, 8, width of operand count N and of OpCount
SATURATE, 0, 0 = wrap-around on overflow; 1 = clamp to all-ones (add) or zero (sub)

Ports:
Clock  in  1  single system clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
Clear  in  1  synchronous clear of A, Overflow, OpCount; returns FSM to IDLE
Start  in  1  begin a run; Count and Sub sampled on this edge
Count  in  CNT_W  number of operands N in the run
Sub  in  1  run mode: 0 = A+B, 1 = A-B
Load  in  1  operand valid; accepted only when Ready=1
DataIN  in  WIDTH  operand value
Ready  out  1  FSM in FETCH, operand can be accepted
Busy  out  1  FSM not in IDLE
Done  out  1  one-cycle pulse at end of run
Overflow  out  1  sticky unsigned carry-out (add) or borrow (sub)
OpCount  out  CNT_W  operands applied in current/last run
DataOut  out  WIDTH  accumulator A

Behaviour:
- Reset (async): A=0, B=0, N=0, mode=add, OpCount=0, Overflow=0, Done=0, state IDLE. This gives Ready=0 and Busy=0.
- State IDLE:
  - Start with Count!=0 -> FETCH. On the same edge: latch N=Count and mode=Sub, set OpCount=0. A is NOT cleared, so runs chain; use Clear to zero A.
  - Start with Count==0 -> DONE. A unchanged.
- State FETCH:
  - Ready=1.
  - Load=1 -> B<=DataIN, go to ADD.
  - Load=0 -> stay in FETCH indefinitely.
- State ADD (one cycle, Ready=0):
  - Compute R = A ± B at WIDTH+1 bits.
  - Wrap mode: A<=R[WIDTH-1:0].
  - Carry/borrow bit set: Overflow<=1. With SATURATE=1, A<=all-ones for add, A<=0 for sub.
  - OpCount<=OpCount+1.
  - If OpCount+1==N -> DONE, else -> FETCH.
- State DONE: Done=1 for exactly one cycle, then IDLE.
- Throughput and latency:
  - One operand per 2 cycles.
  - Load accepted at edge k -> DataOut updated at edge k+1.
  - Done high during the cycle after the last ADD.
- Ignored inputs: Load outside FETCH; Start outside IDLE; Count/Sub changes mid-run.
- Priority: Reset > Clear > Start/Load. Clear in any state -> IDLE, A=0, Overflow=0, OpCount=0, Done=0. B and N keep their values.
- Reset or Clear mid-run abandons the run; no Done pulse is issued.
- Overflow stays set across runs until Clear or Reset.
- All arithmetic is unsigned.

Decomposition:
- Shared package acumulador_pkg:
  - state encoding IDLE/FETCH/ADD/DONE
  - mode constants MODE_ADD=0, MODE_SUB=1
- One sub-module, addsub_sat: combinational WIDTH-bit adder/subtractor with SATURATE parameter. Outputs result and carry/borrow. It generalises the 16-bit full-adder chain.
- The FSM, registers A/B, N and OpCount stay in the top module.

Test Plan:
- Reset asserted mid-cycle -> immediately DataOut=0, Ready=0, Busy=0, Done=0, Overflow=0, OpCount=0.
- Clear; Start Count=3 Sub=0; Load 5, 7, 9 at each Ready -> DataOut=21, OpCount=3, Done high exactly one cycle, Overflow=0.
- No Clear after the previous run; Start Count=2 Sub=1; Load 1, 4 -> DataOut=16. Load held high while Ready=0 -> no extra operand captured.
- WIDTH=16, SATURATE=0: Clear; Count=2; Load 0xFFF0, 0x0020 -> DataOut=0x0010, Overflow=1.
  - SATURATE=1, same stimulus -> DataOut=0xFFFF, Overflow=1.
  - SATURATE=1 sub: 0-1 -> DataOut=0x0000, Overflow=1.
- Start Count=0 -> Done pulses the next cycle, A unchanged. Start pulsed while Busy -> ignored, N unchanged. Load in IDLE -> B unchanged.
- Mid-run: Clear in FETCH after 1 operand -> IDLE, A=0, no Done. Repeat with Reset in ADD -> same result, taking effect without waiting for a clock edge.
